// File: rtl/mac_tree_acc_if.sv
// Beat/result bus of the N-lane dot-product engine.
interface mac_tree_acc_if #(
  parameter int WI = 8,
  parameter int N  = 16,
  parameter int WA = 26
);
  logic                 vld_i;
  logic                 first_i;
  logic                 last_i;
  logic [N*WI-1:0]      win;
  logic [N*WI-1:0]      din;
  logic signed [WA-1:0] bias_i;
  logic signed [WA-1:0] acc_o;
  logic                 vld_o;
  logic                 ovf_o;
  logic                 err_o;

  modport master (output vld_i, first_i, last_i, win, din, bias_i,
                  input  acc_o, vld_o, ovf_o, err_o);
  modport slave  (input  vld_i, first_i, last_i, win, din, bias_i,
                  output acc_o, vld_o, ovf_o, err_o);
endinterface

// File: rtl/mac_tree_acc.sv
// N-lane multiply, registered log2(N) adder tree and framed saturating accumulator.
module mac_lane #(
  parameter int WI    = 8,
  parameter int WMODE = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [WI-1:0]     w,
  input  logic [WI-1:0]     x,
  output logic [2*WI+1:0]   prod
);
  logic signed [WI:0]     w_q, x_q;
  logic signed [2*WI+1:0] p;

  // {w,0}+1 is just {w,1}: odd-encoded weight
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      w_q <= '0;
      x_q <= '0;
    end else if (WMODE == 1) begin
      w_q <= {w, 1'b1};
      x_q <= {1'b0, x};
    end else begin
      w_q <= {w[WI-1], w};
      x_q <= {x[WI-1], x};
    end

  assign p = w_q * x_q;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) prod <= '0;
    else       prod <= p;
endmodule

module mac_tree_acc #(
  parameter int WI    = 8,
  parameter int N     = 16,
  parameter int WN    = $clog2(N),
  parameter int WMODE = 1,
  parameter int WACC  = 4,
  parameter int WT    = 2*WI+2+WN,
  parameter int WA    = WT+WACC
) (
  input  logic          clk,
  input  logic          rstn,
  mac_tree_acc_if.slave bus
);
  localparam int PW     = 2*WI+2;
  // sideband taps: [0] operands, [1] products, [2..WN+1] tree levels
  localparam int STAGES = WN+1;

  typedef enum logic {IDLE, ACC} state_t;

  logic [N-1:0][WI-1:0] w_l, x_l;
  assign w_l = bus.win;
  assign x_l = bus.din;

  for (genvar l = 0; l <= WN; l++) begin : lvl
    localparam int NN = N >> l;
    logic [NN-1:0][PW+l-1:0] node;
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < N; i++) begin : g_lane
        mac_lane #(.WI(WI), .WMODE(WMODE)) u_lane (
          .clk (clk), .rstn(rstn), .w(w_l[i]), .x(x_l[i]), .prod(node[i]));
      end
    end else begin : g_add
      always_ff @(posedge clk or negedge rstn)
        if (!rstn) node <= '0;
        else
          for (int j = 0; j < NN; j++)
            node[j] <= $signed(lvl[l-1].node[2*j]) + $signed(lvl[l-1].node[2*j+1]);
    end
  end

  logic [STAGES:0]         vld_pipe, fst_pipe, lst_pipe;
  logic [STAGES:0][WA-1:0] bias_pipe;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      vld_pipe  <= '0;
      fst_pipe  <= '0;
      lst_pipe  <= '0;
      bias_pipe <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:0],  bus.vld_i};
      fst_pipe  <= {fst_pipe[STAGES-1:0],  bus.first_i};
      lst_pipe  <= {lst_pipe[STAGES-1:0],  bus.last_i};
      bias_pipe <= {bias_pipe[STAGES-1:0], bus.bias_i};
    end

  state_t               state;
  logic signed [WA-1:0] acc, acc_q;
  logic                 ovf, ovf_q, vld_q, err_q;
  logic signed [WT-1:0] tree;
  logic signed [WA-1:0] base, clamped;
  logic signed [WA:0]   sum;
  logic                 start, ovf_n;

  assign tree = $signed(lvl[WN].node[0]);

  // a missing first in IDLE still restarts from the bias
  always_comb begin
    start   = fst_pipe[STAGES] | (state == IDLE);
    base    = start ? $signed(bias_pipe[STAGES]) : acc;
    sum     = base + tree;
    clamped = sum[WA-1:0];
    ovf_n   = ~start & ovf;
    if (sum[WA] != sum[WA-1]) begin
      clamped = sum[WA] ? {1'b1, {(WA-1){1'b0}}} : {1'b0, {(WA-1){1'b1}}};
      ovf_n   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      acc_q <= '0;
      ovf_q <= 1'b0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      err_q <= 1'b0;
      if (vld_pipe[STAGES]) begin
        acc   <= clamped;
        ovf   <= ovf_n;
        err_q <= (state == IDLE) ? ~fst_pipe[STAGES] : fst_pipe[STAGES];
        if (lst_pipe[STAGES]) begin
          acc_q <= clamped;
          ovf_q <= ovf_n;
          vld_q <= 1'b1;
          state <= IDLE;
        end else begin
          state <= ACC;
        end
      end
    end

  assign bus.acc_o = acc_q;
  assign bus.ovf_o = ovf_q;
  assign bus.vld_o = vld_q;
  assign bus.err_o = err_q;
endmodule

// File: tb/tb_mac_tree_acc.sv
// Directed bench for mac_tree_acc: WMODE=1 and WMODE=0 instances, N=16, WI=8.
module tb_mac_tree_acc;
  localparam int WI = 8;
  localparam int N  = 16;
  localparam int WN = 4;
  localparam int WA = 2*WI+2+WN+4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mac_tree_acc_if #(.WI(WI), .N(N), .WA(WA)) b1 ();
  mac_tree_acc_if #(.WI(WI), .N(N), .WA(WA)) b0 ();

  mac_tree_acc #(.WI(WI), .N(N), .WMODE(1)) dut1 (.clk(clk), .rstn(rstn), .bus(b1.slave));
  mac_tree_acc #(.WI(WI), .N(N), .WMODE(0)) dut0 (.clk(clk), .rstn(rstn), .bus(b0.slave));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int se = 0;

  int vcnt1 = 0, ecnt1 = 0, vcyc1 = 0, vcnt0 = 0;
  logic signed [WA-1:0] acc1, acc0;
  logic ovf1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (b1.vld_o === 1'b1) begin
      vcnt1 <= vcnt1 + 1;
      acc1  <= b1.acc_o;
      ovf1  <= b1.ovf_o;
      vcyc1 <= cyc;
    end
    if (b1.err_o === 1'b1) ecnt1 <= ecnt1 + 1;
    if (b0.vld_o === 1'b1) begin
      vcnt0 <= vcnt0 + 1;
      acc0  <= b0.acc_o;
    end
  end

  task automatic beat(input logic [7:0] w, input logic [7:0] x, input logic f, input logic l,
                      input logic signed [WA-1:0] b);
    @(negedge clk);
    b1.vld_i = 1'b1; b1.win = {N{w}}; b1.din = {N{x}};
    b1.first_i = f; b1.last_i = l; b1.bias_i = b;
    se = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      b1.vld_i = 1'b0;
    end
  endtask

  task automatic wait_res(input string nm, input int v0, output bit got);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      b1.vld_i = 1'b0;
      #1;
      if (vcnt1 != v0) got = 1'b1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s: no vld_o within 20 cycles", nm);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({b1.acc_o, b1.vld_o, b1.ovf_o, b1.err_o} !== '0) begin
      errors++;
      $display("FAIL reset: acc=%0d vld=%b ovf=%b err=%b, required all 0",
               b1.acc_o, b1.vld_o, b1.ovf_o, b1.err_o);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_single;
    int v0, e0; bit got;
    v0 = vcnt1; e0 = ecnt1;
    beat(8'h00, 8'h01, 1'b1, 1'b1, '0);
    wait_res("single", v0, got);
    if (got) begin
      checks++;
      if (acc1 !== WA'(16)) begin errors++; $display("FAIL single acc: got %0d exp 16", acc1); end
      checks++;
      if (ovf1 !== 1'b0) begin errors++; $display("FAIL single ovf: got %b exp 0", ovf1); end
      checks++;
      if (vcyc1 != se + WN + 2) begin
        errors++; $display("FAIL single latency: got %0d exp %0d", vcyc1 - se, WN + 2);
      end
      checks++;
      if (ecnt1 != e0) begin errors++; $display("FAIL single err: got %0d pulses exp 0", ecnt1 - e0); end
    end
  endtask

  task automatic test_multi_beat;
    int v0; bit got;
    v0 = vcnt1;
    beat(8'h00, 8'h02, 1'b1, 1'b0, WA'(5));
    beat(8'h00, 8'h02, 1'b0, 1'b0, '0);
    idle(2);
    beat(8'h00, 8'h02, 1'b0, 1'b1, '0);
    wait_res("multi", v0, got);
    if (got) begin
      checks++;
      if (acc1 !== WA'(101)) begin errors++; $display("FAIL multi acc: got %0d exp 101", acc1); end
    end
    idle(8);
    checks++;
    if (vcnt1 != v0 + 1) begin errors++; $display("FAIL multi vld count: got %0d exp 1", vcnt1 - v0); end
  endtask

  task automatic test_signed;
    int v0; bit got;
    v0 = vcnt1;
    beat(8'hFF, 8'hFF, 1'b1, 1'b1, '0);
    wait_res("neg", v0, got);
    if (got) begin
      checks++;
      if (acc1 !== WA'(-4080)) begin errors++; $display("FAIL neg acc: got %0d exp -4080", acc1); end
    end
    v0 = vcnt1;
    beat(8'h7F, 8'hFF, 1'b1, 1'b1, '0);
    wait_res("max_prod", v0, got);
    if (got) begin
      checks++;
      if (acc1 !== WA'(1040400)) begin errors++; $display("FAIL max_prod acc: got %0d exp 1040400", acc1); end
    end
  endtask

  task automatic test_back_to_back;
    int v0; bit got;
    v0 = vcnt1;
    for (int i = 0; i < 33; i++) beat(8'h7F, 8'hFF, i == 0, i == 32, '0);
    wait_res("sat", v0, got);
    if (got) begin
      checks++;
      if (acc1 !== WA'(33554431)) begin errors++; $display("FAIL sat acc: got %0d exp 33554431", acc1); end
      checks++;
      if (ovf1 !== 1'b1) begin errors++; $display("FAIL sat ovf: got %b exp 1", ovf1); end
    end
    v0 = vcnt1;
    beat(8'h00, 8'h01, 1'b1, 1'b1, '0);
    wait_res("ovf_clear", v0, got);
    if (got) begin
      checks++;
      if (ovf1 !== 1'b0) begin errors++; $display("FAIL ovf_clear ovf: got %b exp 0", ovf1); end
    end
  endtask

  task automatic test_framing;
    int v0, e0; bit got;
    v0 = vcnt1; e0 = ecnt1;
    beat(8'h00, 8'h05, 1'b1, 1'b0, WA'(7));
    beat(8'h00, 8'h01, 1'b1, 1'b1, '0);
    wait_res("restart", v0, got);
    idle(4);
    if (got) begin
      checks++;
      if (acc1 !== WA'(16)) begin errors++; $display("FAIL restart acc: got %0d exp 16", acc1); end
    end
    checks++;
    if (vcnt1 != v0 + 1) begin errors++; $display("FAIL restart vld count: got %0d exp 1", vcnt1 - v0); end
    checks++;
    if (ecnt1 != e0 + 1) begin errors++; $display("FAIL restart err: got %0d pulses exp 1", ecnt1 - e0); end
    v0 = vcnt1; e0 = ecnt1;
    beat(8'h00, 8'h01, 1'b0, 1'b1, WA'(3));
    wait_res("nofirst", v0, got);
    if (got) begin
      checks++;
      if (acc1 !== WA'(19)) begin errors++; $display("FAIL nofirst acc: got %0d exp 19", acc1); end
    end
    checks++;
    if (ecnt1 != e0 + 1) begin errors++; $display("FAIL nofirst err: got %0d pulses exp 1", ecnt1 - e0); end
  endtask

  task automatic test_reset_mid;
    int v0, e0;
    v0 = vcnt1; e0 = ecnt1;
    beat(8'h00, 8'h01, 1'b1, 1'b0, WA'(9));
    beat(8'h00, 8'h01, 1'b0, 1'b0, '0);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    b1.vld_i = 1'b0;
    idle(12);
    #1;
    checks++;
    if (vcnt1 != v0) begin errors++; $display("FAIL rst_mid vld count: got %0d exp 0", vcnt1 - v0); end
    checks++;
    if ({b1.acc_o, b1.ovf_o, b1.vld_o, b1.err_o} !== '0) begin
      errors++; $display("FAIL rst_mid outputs: acc=%0d ovf=%b, required 0", b1.acc_o, b1.ovf_o);
    end
    checks++;
    if (ecnt1 != e0) begin errors++; $display("FAIL rst_mid err: got %0d pulses exp 0", ecnt1 - e0); end
    test_single();
  endtask

  task automatic test_wmode0;
    int v0; bit got;
    v0 = vcnt0; got = 1'b0;
    @(negedge clk);
    b0.vld_i = 1'b1; b0.win = {N{8'hFE}}; b0.din = {N{8'h80}};
    b0.first_i = 1'b1; b0.last_i = 1'b1; b0.bias_i = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      b0.vld_i = 1'b0;
      #1;
      if (vcnt0 != v0) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL wmode0: no vld_o within 20 cycles");
    end else if (acc0 !== WA'(4096)) begin
      errors++; $display("FAIL wmode0 acc: got %0d exp 4096", acc0);
    end
  endtask

  initial begin
    b1.vld_i = 1'b0; b1.first_i = 1'b0; b1.last_i = 1'b0;
    b1.win = '0; b1.din = '0; b1.bias_i = '0;
    b0.vld_i = 1'b0; b0.first_i = 1'b0; b0.last_i = 1'b0;
    b0.win = '0; b0.din = '0; b0.bias_i = '0;
    test_reset();
    test_single();
    test_multi_beat();
    test_signed();
    test_back_to_back();
    test_framing();
    test_reset_mid();
    test_wmode0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
